// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-port priority, optional write-to-read
// bypass and a per-register busy scoreboard for multi-cycle producers.
module regfile_mp #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 32,
   parameter int NRD     = 3,
   parameter int NWR     = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_X0 = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NWR-1:0]           we,
   input  logic [NWR*ADDR_W-1:0]    wa,
   input  logic [NWR*DATA_W-1:0]    wd,
   input  logic [NRD*ADDR_W-1:0]    ra,
   output logic [NRD*DATA_W-1:0]    rd,
   output logic [NRD-1:0]           rbusy,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [DEPTH-1:0]         busy_vec
);

   logic [DATA_W-1:0] mem_r  [DEPTH];
   logic [DEPTH-1:0]  busy_r;
   logic [DEPTH-1:0]  wen_s;
   logic [DATA_W-1:0] wdat_s [DEPTH];
   logic              rsv_ok_s;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      addr_ok = (32'(a) < DEPTH) && !((ZERO_X0 != 0) && (a == {ADDR_W{1'b0}}));
   endfunction

   assign rsv_ok_s = rsv_en && addr_ok(rsv_addr);
   assign busy_vec = busy_r;

   // Per-register write resolution; a higher-index port overrides lower ones.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         wen_s[r]  = 1'b0;
         wdat_s[r] = {DATA_W{1'b0}};
         for (int k = 0; k < NWR; k++) begin
            logic hit;
            hit = we[k] && addr_ok(wa[k*ADDR_W +: ADDR_W]) &&
                  (wa[k*ADDR_W +: ADDR_W] == ADDR_W'(r));
            wen_s[r]  = wen_s[r] | hit;
            wdat_s[r] = hit ? wd[k*DATA_W +: DATA_W] : wdat_s[r];
         end
      end
   end

   // Read ports: invalid/zero address first, then same-cycle bypass, then stored state.
   always_comb begin
      rd    = {(NRD*DATA_W){1'b0}};
      rbusy = {NRD{1'b0}};
      for (int j = 0; j < NRD; j++) begin
         logic [ADDR_W-1:0] a;
         a = ra[j*ADDR_W +: ADDR_W];
         if (!addr_ok(a)) begin
            rd[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            rbusy[j]               = 1'b0;
         end else if ((BYPASS != 0) && wen_s[a]) begin
            rd[j*DATA_W +: DATA_W] = wdat_s[a];
            rbusy[j]               = 1'b0;
         end else begin
            rd[j*DATA_W +: DATA_W] = mem_r[a];
            rbusy[j]               = busy_r[a];
         end
      end
   end

   // Array and scoreboard update; a reservation outranks a completing write
   // because it names a newer producer.
   always_ff @(posedge clk) begin
      for (int r = 0; r < DEPTH; r++) begin
         if (rst) begin
            mem_r[r]  <= {DATA_W{1'b0}};
            busy_r[r] <= 1'b0;
         end else begin
            if (wen_s[r]) begin
               mem_r[r] <= wdat_s[r];
            end
            if (rsv_ok_s && (rsv_addr == ADDR_W'(r))) begin
               busy_r[r] <= 1'b1;
            end else if (wen_s[r]) begin
               busy_r[r] <= 1'b0;
            end
         end
      end
   end

endmodule
